// File: rtl/capture_stimulus_gen.sv
// capture_stimulus_gen
//   Write-side stimulus source for the analyzer capture path. On start it
//   streams the counting pattern 0..LAST, one word per non-stalled cycle,
//   pulses trigger_out alongside the word equal to TRIGGER_VALUE, then parks
//   in DONE holding LAST on data_in. LAST leaves room for the whole
//   post-trigger window (buffer depth + holdoff + alignment delay).
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   start          in   run request, honoured in IDLE or DONE only
//   stall          in   downstream not ready; freeze the pattern this cycle
//   data_in        out  generated sample word
//   data_in_valid  out  data_in carries a new word this cycle
//   trigger_out    out  one-cycle pulse with the TRIGGER_VALUE word
//   busy           out  high while running
//   done           out  high after a completed run until the next start
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | emitting words, cnt is the next word to emit
// DONE  | LAST emitted, waiting for start
module capture_stimulus_gen #(
  parameter int DATA_WIDTH      = 8,
  parameter int MEMORY_SIZE     = 16,
  parameter int USER_HOLDOFF    = 4,
  parameter int ALIGNMENT_DELAY = 2,
  parameter int TRIGGER_VALUE   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_in_valid,
  output logic                  trigger_out,
  output logic                  busy,
  output logic                  done
);

  localparam int POST_COUNT = MEMORY_SIZE + USER_HOLDOFF + ALIGNMENT_DELAY;
  localparam int LAST       = TRIGGER_VALUE + POST_COUNT;

  // The pattern must fit the word so it can never wrap inside a run.
  if (LAST >= (2 ** DATA_WIDTH)) begin : g_last_check
    $error("capture_stimulus_gen: LAST (%0d) does not fit in DATA_WIDTH bits", LAST);
  end

  localparam logic [DATA_WIDTH-1:0] LAST_W = DATA_WIDTH'(LAST);
  localparam logic [DATA_WIDTH-1:0] TRIG_W = DATA_WIDTH'(TRIGGER_VALUE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  valid_nxt, trig_nxt, busy_nxt, done_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      data_in       <= '0;
      data_in_valid <= 1'b0;
      trigger_out   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      data_in       <= data_nxt;
      data_in_valid <= valid_nxt;
      trigger_out   <= trig_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_in;
    valid_nxt = 1'b0;
    trig_nxt  = 1'b0;
    busy_nxt  = busy;
    done_nxt  = done;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          data_nxt  = cnt;
          valid_nxt = 1'b1;
          trig_nxt  = (cnt == TRIG_W);
          cnt_nxt   = cnt + 1'b1;
          // busy/done flip one edge later, in DONE, so LAST still shows busy
          if (cnt == LAST_W) state_nxt = DONE;
        end
      end
      DONE: begin
        busy_nxt = 1'b0;
        done_nxt = 1'b1;
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_capture_stimulus_gen.sv
module tb_capture_stimulus_gen;

  localparam int DW    = 8;
  localparam int ALIGN = 2;
  localparam int TRIG  = 8;
  localparam int LAST  = 30;

  logic          clk = 1'b0;
  logic          reset, start, stall;
  logic [DW-1:0] data_in;
  logic          data_in_valid, trigger_out, busy, done;

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];
  int trig_count  = 0;
  int mon_e;

  always #5 clk = ~clk;

  capture_stimulus_gen #(
    .DATA_WIDTH(DW), .MEMORY_SIZE(16), .USER_HOLDOFF(4),
    .ALIGNMENT_DELAY(ALIGN), .TRIGGER_VALUE(TRIG)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .trigger_out(trigger_out), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pop one expected word per valid output.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_in_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_word got=%0d want=none at %0t", data_in, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word", int'(data_in), mon_e);
          chk("trig_with_word", int'(trigger_out), int'(mon_e == TRIG));
        end
      end else if (trigger_out) begin
        chk("trig_without_valid", 1, 0);
      end
      if (trigger_out) trig_count++;
    end
  end

  // Alignment pipe feeding a readback-style checker of the delayed stream.
  logic [DW-1:0] pd [ALIGN];
  logic          pv [ALIGN];
  logic [DW-1:0] chk_next    = '0;
  logic          test_failed = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ALIGN; i++) begin
        pd[i] <= '0;
        pv[i] <= 1'b0;
      end
    end else begin
      if (pv[ALIGN-1]) begin
        if (pd[ALIGN-1] != 0 && pd[ALIGN-1] != chk_next) test_failed <= 1'b1;
        chk_next <= pd[ALIGN-1] + 1'b1;
      end
      pd[0] <= data_in;
      pv[0] <= data_in_valid;
      for (int i = 1; i < ALIGN; i++) begin
        pd[i] <= pd[i-1];
        pv[i] <= pv[i-1];
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"},  int'(data_in), 0);
    chk({tag, "_valid"}, int'(data_in_valid), 0);
    chk({tag, "_trig"},  int'(trigger_out), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(done), 0);
  endtask

  // One run: optional stall before word 8, start re-pulse, or mid-run reset.
  task automatic do_run(input int stall_at, input int restart_at,
                        input int abort_at, input int was_done);
    int  last_word;
    bit  fin;
    last_word  = (abort_at >= 0) ? abort_at : LAST;
    fin        = 1'b0;
    trig_count = 0;
    for (int w = 0; w <= last_word; w++) exp_q.push_back(w);
    @(negedge clk);
    chk("done_before_start", int'(done), was_done);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("done_after_start", int'(done), 0);
    chk("valid_after_start", int'(data_in_valid), 0);
    for (int n = 0; n < 300 && !fin; n++) begin
      @(negedge clk);
      if (data_in_valid && int'(data_in) == stall_at) begin
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("stall_valid", int'(data_in_valid), 0);
          chk("stall_hold", int'(data_in), stall_at);
          chk("stall_trig", int'(trigger_out), 0);
        end
        stall = 1'b0;
      end else if (data_in_valid && int'(data_in) == restart_at) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end else if (data_in_valid && int'(data_in) == abort_at) begin
        #2 reset = 1'b1;
        #1 check_all_zero("abort");
        @(posedge clk); #1 reset = 1'b0;
        fin = 1'b1;
      end else if (data_in_valid && int'(data_in) == LAST) begin
        @(negedge clk);
        chk("end_done", int'(done), 1);
        chk("end_busy", int'(busy), 0);
        chk("end_valid", int'(data_in_valid), 0);
        chk("end_data_holds_last", int'(data_in), LAST);
        fin = 1'b1;
      end
    end
    chk("run_finished", int'(fin), 1);
    chk("words_left", exp_q.size(), 0);
    chk("trigger_count", trig_count, 1);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    #12 check_all_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    do_run(-1, -1, -1, 0);  // plain run
    do_run(-1, -1, -1, 1);  // start from DONE repeats identically
    do_run( 7, -1, -1, 1);  // stall while word 8 is pending
    do_run(-1, 12, -1, 1);  // start re-pulse mid-run is ignored
    do_run(-1, -1, 20, 1);  // asynchronous reset at word 20
    do_run(-1, -1, -1, 0);  // restart from IDLE after the abort

    repeat (ALIGN + 2) @(negedge clk);
    chk("pipe_checker_failed", int'(test_failed), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
